// File: rtl/example_adder_pkg.sv
// example_adder_pkg: shared width, operand/result types and a reference add
// used by the behavioural datapath of example_adder.
package example_adder_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic  carry;
    data_t sum;
  } add_res_t;

  // Full-width add: sum is modulo 2^DATA_W, overflow lands in carry.
  function automatic add_res_t add_full(input data_t a, input data_t b);
    logic [DATA_W:0] wide;
    add_res_t        res;
    wide      = {1'b0, a} + {1'b0, b};
    res.carry = wide[DATA_W];
    res.sum   = wide[DATA_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/design_v.sv
// design_v: connection bundle for example_adder (clock, active-low reset,
// operands and registered result).
interface design_v;
  import example_adder_pkg::*;

  logic  clk;
  logic  rst;
  data_t adder_example_a_in;
  data_t adder_example_b_in;
  data_t adder_example_sum_out;
  logic  adder_example_carry_out;
  logic  adder_example_valid_out;

  modport dut (
    input  clk,
    input  rst,
    input  adder_example_a_in,
    input  adder_example_b_in,
    output adder_example_sum_out,
    output adder_example_carry_out,
    output adder_example_valid_out
  );

  modport tb (
    output clk,
    output rst,
    output adder_example_a_in,
    output adder_example_b_in,
    input  adder_example_sum_out,
    input  adder_example_carry_out,
    input  adder_example_valid_out
  );

endinterface

// File: rtl/example_adder_ripple_carry_adder.sv
// ripple_carry_adder: purely combinational WIDTH-bit ripple-carry adder
// built from per-bit full-adder equations.
module ripple_carry_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Carry is carried in a scalar through the loop so the chain is a single
  // ordered evaluation rather than a self-referencing vector.
  always_comb begin
    logic carry;
    sum   = '0;
    carry = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/example_adder.sv
// example_adder: registered unsigned adder behind the design_v interface.
// RIPPLE=1 uses ripple_carry_adder, RIPPLE=0 a behavioural add; results match.
// Optional macro ADDER_EXAMPLE_SAT_EN: saturate the sum to all-ones on carry.
module example_adder #(
  parameter int unsigned DATA_W = example_adder_pkg::DATA_W,
  parameter int unsigned RIPPLE = 1
) (
  design_v.dut pins
);
  import example_adder_pkg::*;

  logic [DATA_W-1:0] raw_sum;
  logic              raw_carry;
  logic [DATA_W-1:0] next_sum;
  logic [DATA_W-1:0] sum_q;
  logic              carry_q;
  logic [1:0]        rel_sync;

  generate
    if (RIPPLE == 1) begin : g_ripple
      ripple_carry_adder #(
        .WIDTH(DATA_W)
      ) u_rca (
        .a   (pins.adder_example_a_in),
        .b   (pins.adder_example_b_in),
        .cin (1'b0),
        .sum (raw_sum),
        .cout(raw_carry)
      );
    end else begin : g_behav
      add_res_t res;
      // Behavioural add through the package reference function.
      always_comb begin
        res = add_full(pins.adder_example_a_in, pins.adder_example_b_in);
      end
      assign raw_sum   = res.sum;
      assign raw_carry = res.carry;
    end
  endgenerate

  // Select the value presented to the sum register.
  always_comb begin
    next_sum = raw_sum;
`ifdef ADDER_EXAMPLE_SAT_EN
    if (raw_carry) begin
      next_sum = '1;
    end
`endif
  end

  // Reset release synchroniser: asserts immediately, releases after two edges.
  // Its second stage doubles as the valid flag.
  always_ff @(posedge pins.clk or negedge pins.rst) begin
    if (!pins.rst) begin
      rel_sync <= '0;
    end else begin
      rel_sync <= {rel_sync[0], 1'b1};
    end
  end

  // Result registers: load on the same edge the valid stage rises, so the
  // first valid result comes from inputs sampled on that edge.
  always_ff @(posedge pins.clk or negedge pins.rst) begin
    if (!pins.rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (rel_sync[0]) begin
      sum_q   <= next_sum;
      carry_q <= raw_carry;
    end
  end

  assign pins.adder_example_sum_out   = sum_q;
  assign pins.adder_example_carry_out = carry_q;
  assign pins.adder_example_valid_out = rel_sync[1];

endmodule

// File: tb/tb_example_adder.sv
// tb_example_adder: scoreboard bench for example_adder in both RIPPLE modes.
// The driver pushes the expected response for each upcoming posedge; the
// monitor pops one entry per posedge and compares both DUT instances.
module tb_example_adder;
  import example_adder_pkg::*;

  typedef struct {
    bit    rst_lo;
    bit    valid;
    data_t sum;
    bit    carry;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned hi_edges = 0;
  logic        clk = 1'b0;

  always #5 clk = ~clk;

  design_v bus_r ();
  design_v bus_b ();

  assign bus_r.clk = clk;
  assign bus_b.clk = clk;

  example_adder #(.RIPPLE(1)) dut_r (.pins(bus_r.dut));
  example_adder #(.RIPPLE(0)) dut_b (.pins(bus_b.dut));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare one DUT's outputs with a scoreboard entry.
  task automatic cmp(input string tag, input logic valid, input data_t sum,
                     input logic carry, input exp_t e);
    if (e.rst_lo) begin
      check({tag, "_reset_valid"}, 32'(valid), 32'd0);
      check({tag, "_reset_sum"},   32'(sum),   32'd0);
      check({tag, "_reset_carry"}, 32'(carry), 32'd0);
    end else begin
      check({tag, "_valid"}, 32'(valid), 32'(e.valid));
      if (e.valid) begin
        check({tag, "_sum"},   32'(sum),   32'(e.sum));
        check({tag, "_carry"}, 32'(carry), 32'(e.carry));
      end
    end
  endtask

  // Drive inputs for the next posedge and record what that edge must produce.
  task automatic apply(input bit r, input data_t a, input data_t b);
    exp_t       e;
    logic [8:0] w;
    bus_r.rst = r;
    bus_b.rst = r;
    bus_r.adder_example_a_in = a;
    bus_r.adder_example_b_in = b;
    bus_b.adder_example_a_in = a;
    bus_b.adder_example_b_in = b;
    hi_edges = r ? hi_edges + 1 : 0;
    w = 9'(a) + 9'(b);
    e.rst_lo = !r;
    e.valid  = (hi_edges >= 2);
    e.carry  = w[8];
    e.sum    = w[7:0];
`ifdef ADDER_EXAMPLE_SAT_EN
    if (w > 9'd255) e.sum = 8'hFF;
`endif
    sb.push_back(e);
  endtask

  task automatic step(input bit r, input data_t a, input data_t b);
    @(negedge clk);
    apply(r, a, b);
  endtask

  function automatic data_t rnd();
    return 8'($urandom);
  endfunction

  // Monitor: one scoreboard entry per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow actual=0 required=1 at %0t", $time);
      end else begin
        e = sb.pop_front();
        cmp("ripple", bus_r.adder_example_valid_out, bus_r.adder_example_sum_out,
            bus_r.adder_example_carry_out, e);
        cmp("behav", bus_b.adder_example_valid_out, bus_b.adder_example_sum_out,
            bus_b.adder_example_carry_out, e);
      end
    end
  end

  initial begin
    data_t da [4] = '{8'h12, 8'hFF, 8'hFF, 8'h00};
    data_t db [4] = '{8'h34, 8'h01, 8'hFF, 8'h00};

    // Reset held across several edges with unknown and random operands.
    apply(1'b0, 'x, 'x);
    repeat (3) step(1'b0, rnd(), rnd());

    // Release; the first edge after release is not yet valid.
    step(1'b1, rnd(), rnd());

    // Directed: basic, wrap, max+max, zero.
    for (int unsigned i = 0; i < 4; i++) step(1'b1, da[i], db[i]);

    repeat (40) step(1'b1, rnd(), rnd());

    // Mid-run reset: outputs must clear without waiting for a clock edge.
    @(negedge clk);
    apply(1'b0, rnd(), rnd());
    #1;
    check("async_clear_valid", 32'(bus_r.adder_example_valid_out), 32'd0);
    check("async_clear_sum",   32'(bus_r.adder_example_sum_out),   32'd0);
    check("async_clear_carry", 32'(bus_b.adder_example_carry_out), 32'd0);
    check("async_clear_bvalid", 32'(bus_b.adder_example_valid_out), 32'd0);

    step(1'b1, rnd(), rnd());
    repeat (20) step(1'b1, rnd(), rnd());
    step(1'b1, 8'hFF, 8'h01);
    step(1'b1, 8'hFF, 8'hFF);

    @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/example_adder.md
Name: example_adder

Overview:
- Registered unsigned adder, DATA_W bits wide, accessed through the `design_v` SystemVerilog interface.
- The DUT exposes a single interface port, `pins`, of type `design_v`; all signals below live in that interface.
- Used as the reference/example block for interface-based connection in the 8-bit datapath (AES/AHB) work.
- Inputs are sampled every clock; there is no input handshake. The result is registered with 1-cycle latency.

Parameters:
- DATA_W, default 8: operand and sum width (shared value from the package).
- RIPPLE, default 1: 1 selects the explicit ripple-carry sub-module; 0 uses a behavioural `+`. Results must be identical in both modes.

Ports:
- pins  interface  design_v  bundle containing the signals below; `example_adder` uses modport `dut`.
- clk  input  1  single clock, driven by the bench through the interface.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- adder_example_a_in  input  DATA_W  operand A. Wider drivers are truncated to the LSBs on assignment.
- adder_example_b_in  input  DATA_W  operand B, truncated the same way.
- adder_example_sum_out  output  DATA_W  registered sum.
- adder_example_carry_out  output  1  registered carry-out of the DATA_W-bit add.
- adder_example_valid_out  output  1  high when the sum/carry registers hold a result computed from sampled inputs.

Behaviour:
- Reset: while rst=0, sum_out=0, carry_out=0, valid_out=0, asynchronously and immediately.
- Reset release: release is synchronised internally with a 2-flop release synchroniser; assertion is not synchronised.
- Normal operation, each posedge clk with reset released:
  - {carry, sum} = a_in + b_in, computed at DATA_W+1 bits.
  - sum_out <= sum; carry_out <= carry.
  - valid_out <= 1.
- Latency: exactly 1 clock from input sample to output.
- Throughput: a new result every cycle; inputs are fully pipelined.
- Wrap-around: the sum is modulo 2^DATA_W and the overflow appears on carry_out. Example: 0xFF+0x01 gives sum 0x00, carry 1.
- Boundaries:
  - 0+0 gives 0 with carry 0.
  - Max+max gives 2^DATA_W−2 with carry 1.
- Inputs changing on negedge (bench style) are stable by the next posedge; no combinational input-to-output path is allowed.
- Reset mid-operation: outputs clear within the same cycle. After release, valid_out returns high on the first posedge after the synchroniser releases (at most 2 cycles after rst rises). Previous results are not retained.
- X on inputs while rst=0 must not propagate to outputs.

Optional Feature:
- Macro: ADDER_EXAMPLE_SAT_EN.
- Defined: saturating mode.
  - If carry=1, sum_out <= all-ones (0xFF for DATA_W=8) and carry_out <= 1, acting as a sticky overflow indication for that cycle only.
  - Otherwise the output is identical to normal mode.
- Undefined: modulo wrap-around as described in Behaviour; no saturation logic is synthesised.

Decomposition:
- Package `example_adder_pkg` holds:
  - localparam DATA_W = 8;
  - typedef `data_t` (logic [DATA_W-1:0]);
  - typedef struct `add_res_t` {logic carry; data_t sum;}.
- Interface `design_v` imports the package and declares the clk, rst, a/b/sum/carry/valid signals.
- Modports:
  - `dut`: clk, rst, a, b as inputs; sum, carry, valid as outputs.
  - `tb`: the mirror of `dut`.
- One natural sub-module: `ripple_carry_adder` (DATA_W-bit, combinational, cin tied to 0). It is instantiated when RIPPLE=1.

Test Plan:
- Reset: rst=0 for 10 ns with random inputs → sum_out=0, carry_out=0, valid_out=0 throughout; valid_out=1 within 2 cycles after rst=1.
- Basic: a=0x12, b=0x34 at negedge → next posedge sum_out=0x46, carry_out=0.
- Wrap: a=0xFF, b=0x01 → sum_out=0x00, carry_out=1. With ADDER_EXAMPLE_SAT_EN defined → sum_out=0xFF, carry_out=1.
- Extremes: a=0xFF, b=0xFF → sum_out=0xFE, carry_out=1; a=0, b=0 → 0/0.
- Random: 10+ cycles of $urandom on both operands (truncated to 8 bits) → each output equals the truncated a+b from the previous cycle; the scoreboard compares against a 9-bit model.
- Mid-run reset: drop rst for 1 cycle during random traffic → outputs clear immediately, then results resume matching the model after release.
